// File: rtl/bin_mult_pkg.sv
// Shared definitions for the multiplier accumulate stage: FSM state encoding and
// the accumulator width derived from operand width plus guard bits.
package bin_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int D_DEFAULT     = 16;
    localparam int G_DEFAULT     = 8;
    localparam int LEN_W_DEFAULT = 8;

    // Product is 2*d bits wide; g guard bits absorb carries from up to 2^g products.
    function automatic int acc_width(input int d, input int g);
        return 2 * d + g;
    endfunction

endpackage

// File: rtl/bin_mult_accumulator_if.sv
// Product-in / result-out bundle between the multiplier and the accumulate stage.
// The master drives products and control; the slave (accumulator) returns the result.
interface bin_mult_accumulator_if #(
    parameter int D     = bin_mult_pkg::D_DEFAULT,
    parameter int G     = bin_mult_pkg::G_DEFAULT,
    parameter int LEN_W = bin_mult_pkg::LEN_W_DEFAULT
);
    localparam int ACC_W = bin_mult_pkg::acc_width(D, G);

    logic               start;
    logic [LEN_W-1:0]   len;
    logic               clear;
    logic               prod_valid;
    logic [2*D-1:0]     prod;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [ACC_W-1:0]   res_data;
    logic               ovf;
    logic               drop;

    modport master (
        output start, len, clear, prod_valid, prod, res_ready,
        input  busy, res_valid, res_data, ovf, drop
    );

    modport slave (
        input  start, len, clear, prod_valid, prod, res_ready,
        output busy, res_valid, res_data, ovf, drop
    );

endinterface

// File: rtl/bin_mult_accumulator.sv
// Sums a programmed number of unsigned products into a wide accumulator and holds
// the result behind a valid/ready handshake; all outputs are registered.
module bin_mult_accumulator
    import bin_mult_pkg::*;
#(
    parameter int D     = D_DEFAULT,
    parameter int G     = G_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_mult_accumulator_if.slave  bus
);
    localparam int ACC_W = acc_width(D, G);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    res_data_q, res_data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;
    logic [ACC_W:0]      sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        len_d       = len_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        // Extra top bit of the adder is the carry-out that flags wrap-around.
        sum         = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod);

        if (bus.clear) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            acc_d       = '0;
            count_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        drop_d  = 1'b0;
                        if (bus.len != '0) begin
                            len_d   = bus.len;
                            state_d = ST_ACCUM;
                        end else begin
                            res_data_d  = '0;
                            res_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end else if (bus.prod_valid) begin
                        drop_d = 1'b1;
                    end
                end

                ST_ACCUM: begin
                    if (bus.prod_valid) begin
                        acc_d   = sum[ACC_W-1:0];
                        count_d = count_q + LEN_W'(1);
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
                        if (count_q == len_q - LEN_W'(1)) begin
                            res_data_d  = sum[ACC_W-1:0];
                            res_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.prod_valid) begin
                        drop_d = 1'b1;
                    end
                    // A start in the handshake cycle is deliberately not taken.
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end

                default: begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            res_data_q  <= '0;
            len_q       <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            len_q       <= len_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop      = drop_q;

endmodule
